// File: rtl/booth_pkg.sv
// Shared types and sizes for the Booth partial-product reduction stage.
package booth_pkg;

  localparam int NUM_PP = 16;
  localparam int PP_W   = 34;
  localparam int PROD_W = 64;

  typedef logic [PP_W-1:0] pp_t;
  typedef pp_t [NUM_PP-1:0] pp_array_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/booth_pp_weight.sv
// Weighted contribution of one Booth partial product:
// (sign_extend(T) + c) << (2*idx), where pp = {T[32:0], c}.
module booth_pp_weight
  import booth_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  pp_t               pp,
  input  logic [IDX_W-1:0]  idx,
  output logic [PROD_W-1:0] contrib
);

  logic [PROD_W-1:0] term_s;

  // Sign-extend the term, fold in the negate correction, then apply radix-4 weight.
  always_comb begin
    term_s  = {{(PROD_W-PP_W+1){pp[PP_W-1]}}, pp[PP_W-1:1]}
            + {{(PROD_W-1){1'b0}}, pp[0]};
    contrib = term_s << {idx, 1'b0};
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Iterative reduction of a radix-4 Booth partial-product set into a 64-bit product.
// Optional macro BOOTH_ACC_EARLY_DONE_EN finishes early once the remaining PPs are all zero.
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int PPS_PER_CYCLE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_PP*PP_W-1:0] pp_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PROD_W-1:0]      product,
  output logic                   busy
);

  localparam int GROUPS = NUM_PP / PPS_PER_CYCLE;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IDX_W  = $clog2(NUM_PP);

  acc_state_e        state_r, state_next_s;
  pp_array_t         pp_hold_r;
  logic [PROD_W-1:0] acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [PROD_W-1:0] product_r;
  logic              in_ready_r, out_valid_r, busy_r;
  logic              last_group_s;
  logic [IDX_W-1:0]  idx_s     [PPS_PER_CYCLE];
  logic [PROD_W-1:0] contrib_s [PPS_PER_CYCLE];
  logic [PROD_W-1:0] group_sum_s;

  // PP indices covered by the current group.
  always_comb begin
    for (int j = 0; j < PPS_PER_CYCLE; j++) begin
      idx_s[j] = IDX_W'(int'(cnt_r) * PPS_PER_CYCLE + j);
    end
  end

  for (genvar j = 0; j < PPS_PER_CYCLE; j++) begin : g_weight
    booth_pp_weight #(.IDX_W(IDX_W)) u_weight (
      .pp      (pp_hold_r[idx_s[j]]),
      .idx     (idx_s[j]),
      .contrib (contrib_s[j])
    );
  end

  // Sum of the weighted terms in the current group.
  always_comb begin
    group_sum_s = {PROD_W{1'b0}};
    for (int j = 0; j < PPS_PER_CYCLE; j++) begin
      group_sum_s = group_sum_s + contrib_s[j];
    end
  end

`ifdef BOOTH_ACC_EARLY_DONE_EN
  logic tail_zero_s;

  // High when every PP from the current group upward is all-zero.
  always_comb begin
    tail_zero_s = 1'b1;
    for (int i = 0; i < NUM_PP; i++) begin
      if ((i >= int'(cnt_r) * PPS_PER_CYCLE) && (pp_hold_r[i] != {PP_W{1'b0}})) begin
        tail_zero_s = 1'b0;
      end else begin
        tail_zero_s = tail_zero_s;
      end
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    last_group_s = (cnt_r == CNT_W'(GROUPS - 1));
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = ACCUM;
        else          state_next_s = IDLE;
      end
      ACCUM: begin
`ifdef BOOTH_ACC_EARLY_DONE_EN
        if (last_group_s || tail_zero_s) state_next_s = DONE;
        else                             state_next_s = ACCUM;
`else
        if (last_group_s) state_next_s = DONE;
        else              state_next_s = ACCUM;
`endif
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs. When the tail is zero the
  // group sum is zero too, so acc + group_sum equals acc on an early finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pp_hold_r   <= {(NUM_PP*PP_W){1'b0}};
      acc_r       <= {PROD_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      product_r   <= {PROD_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == IDLE);
      out_valid_r <= (state_next_s == DONE);
      busy_r      <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            pp_hold_r <= pp_array_t'(pp_in);
            acc_r     <= {PROD_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
          end
        end
        ACCUM: begin
          acc_r <= acc_r + group_sum_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (state_next_s == DONE) product_r <= acc_r + group_sum_s;
        end
        DONE: begin
          acc_r <= acc_r;
        end
        default: begin
          acc_r <= {PROD_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign product   = product_r;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Randomized self-checking bench for booth_pp_accumulator against an arithmetic product model.
module tb_booth_pp_accumulator;

  localparam int NUM_PP = 16;
  localparam int PP_W   = 34;
  localparam int K      = 2;
  localparam int GROUPS = NUM_PP / K;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_PP*PP_W-1:0] pp_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [63:0]            product;
  logic                   busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [32:0] t_q [NUM_PP];
  logic        c_q [NUM_PP];

  booth_pp_accumulator #(.PPS_PER_CYCLE(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp_in     (pp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] model_product();
    longint signed sum = 0;
    for (int i = 0; i < NUM_PP; i++) begin
      longint signed v;
      v = $signed(t_q[i]);
      v = v + longint'(c_q[i]);
      sum = sum + (v <<< (2 * i));
    end
    return sum;
  endfunction

  function automatic int model_latency();
`ifdef BOOTH_ACC_EARLY_DONE_EN
    for (int g = 0; g < GROUPS; g++) begin
      bit zero = 1'b1;
      for (int i = g * K; i < NUM_PP; i++)
        if (t_q[i] != 33'd0 || c_q[i] != 1'b0) zero = 1'b0;
      if (zero) return g + 1;
    end
`endif
    return GROUPS;
  endfunction

  function automatic logic [NUM_PP*PP_W-1:0] pack_pps();
    logic [NUM_PP*PP_W-1:0] p;
    for (int i = 0; i < NUM_PP; i++) p[i*PP_W +: PP_W] = {t_q[i], c_q[i]};
    return p;
  endfunction

  task automatic clear_pps();
    for (int i = 0; i < NUM_PP; i++) begin
      t_q[i] = 33'd0;
      c_q[i] = 1'b0;
    end
  endtask

  task automatic random_pps(input int zero_from);
    for (int i = 0; i < NUM_PP; i++) begin
      if (i >= zero_from) begin
        t_q[i] = 33'd0;
        c_q[i] = 1'b0;
      end else begin
        t_q[i] = 33'({$urandom, $urandom});
        c_q[i] = 1'($urandom);
      end
    end
  endtask

  // One full transaction, starting and ending #1 after a rising edge.
  task automatic run_op(input string tag, input int bp_cycles, input bit hold_ready);
    logic [63:0] exp;
    int lat;
    int cyc;
    exp = model_product();
    lat = model_latency();
    out_ready = hold_ready;
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    pp_in    = pack_pps();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pp_in    = ~pp_in;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_product"}, product, exp);
    check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    if (hold_ready) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_one_cycle_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_hold"}, product, exp);
    end else begin
      for (int n = 0; n < bp_cycles; n++) begin
        in_valid = 1'b1;
        pp_in    = ~pp_in;
        @(posedge clk); #1;
        check({tag, "_bp_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_bp_product"}, product, exp);
        check({tag, "_bp_in_ready"}, 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
      check({tag, "_post_busy"}, 64'(busy), 64'd0);
      check({tag, "_post_hold"}, product, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    pp_in     = '0;
    clear_pps();
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    clear_pps();
    run_op("zero", 0, 1'b0);
    t_q[0] = 33'd5;
    run_op("pp0_t5", 0, 1'b0);
    clear_pps();
    t_q[1] = 33'h1_FFFF_FFFF;
    run_op("pp1_neg1", 0, 1'b0);
    c_q[1] = 1'b1;
    run_op("pp1_neg1_c", 0, 1'b0);
    clear_pps();
    t_q[15] = 33'd1;
    c_q[15] = 1'b1;
    run_op("pp15", 0, 1'b0);
    random_pps(NUM_PP);
    run_op("backpressure", 5, 1'b0);
    random_pps(NUM_PP);
    run_op("hold_ready", 0, 1'b1);

    // Abort mid-accumulation; the tail PP is nonzero so the run is still accumulating.
    random_pps(NUM_PP);
    t_q[15] = 33'd3;
    pp_in    = pack_pps();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_product", product, 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_busy", 64'(busy), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_pps();
    t_q[0] = 33'd7;
    run_op("after_abort", 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      random_pps(($urandom_range(1, 0) == 1) ? int'($urandom_range(NUM_PP, 0)) : NUM_PP);
      run_op($sformatf("rand%0d", r), int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
